// File: rtl/seg_pkg.sv
// Shared definitions for the multiplexed hex display drivers.
package seg_pkg;

    localparam int DIGIT_W = 4;
    localparam logic [DIGIT_W-1:0] SEG_BLANK = 4'h0;

    // Bit k set when digit k and every digit above it are zero; digit 0 is never set.
    function automatic logic [15:0] lz_mask(input logic [63:0] shadow, input int digits);
        logic [15:0] mask;
        logic all_zero;
        mask = '0;
        all_zero = 1'b1;
        for (int k = 15; k >= 1; k--) begin
            if (k < digits) begin
                all_zero = all_zero && (shadow[4*k +: 4] == 4'h0);
                mask[k] = all_zero;
            end
        end
        return mask;
    endfunction

endpackage

// File: rtl/seg_scan_mux_scan_divider.sv
// Free-running divider producing a one-cycle tick every DIV clock cycles.
module scan_divider #(
    parameter int DIV = 100000
) (
    input  logic clk,
    input  logic rstn,
    output logic tick
);

    localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CW-1:0] LAST = CW'(DIV - 1);

    logic [CW-1:0] cnt;

    assign tick = (cnt == LAST);

    always_ff @(posedge clk) begin
        if (!rstn) begin
            cnt <= '0;
        end else if (tick) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

endmodule

// File: rtl/seg_scan_mux.sv
// Time-multiplexed hex display driver with frame-aligned double buffering
// and optional leading-zero blanking.
module seg_scan_mux
    import seg_pkg::*;
#(
    parameter int DIGITS   = 8,
    parameter int SCAN_DIV = 100000,
    localparam int IDX_W   = $clog2(DIGITS)
) (
    input  logic                        clk,
    input  logic                        rstn,
    input  logic [DIGIT_W*DIGITS-1:0]   data,
    input  logic                        load,
    input  logic                        lz_blank,
    output logic [IDX_W-1:0]            an,
    output logic [DIGIT_W-1:0]          seg,
    output logic                        blank,
    output logic                        pending,
    output logic                        frame_done
);

    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DIGITS - 1);

    logic                              tick;
    logic                              boundary;
    logic [IDX_W-1:0]                  idx;
    logic [DIGITS-1:0][DIGIT_W-1:0]    shadow;
    logic [DIGITS-1:0][DIGIT_W-1:0]    pend_buf;
    logic [15:0]                       mask_all;
    logic [DIGITS-1:0]                 lz_vec;
    logic                              blanked;
    logic                              mask_hi_unused;

    scan_divider #(
        .DIV (SCAN_DIV)
    ) u_div (
        .clk  (clk),
        .rstn (rstn),
        .tick (tick)
    );

    assign boundary = tick && (idx == IDX_LAST);

    always_comb begin
        mask_all = lz_mask(64'(shadow), DIGITS);
        lz_vec   = mask_all[DIGITS-1:0];
        blanked  = lz_blank && lz_vec[idx];
    end

    assign mask_hi_unused = ^mask_all;

    always_ff @(posedge clk) begin
        if (!rstn) begin
            idx        <= '0;
            shadow     <= '0;
            pend_buf   <= '0;
            pending    <= 1'b0;
            frame_done <= 1'b0;
            an         <= '0;
            seg        <= SEG_BLANK;
            blank      <= 1'b1;
        end else begin
            if (tick) begin
                idx <= boundary ? '0 : idx + 1'b1;
            end

            an         <= idx;
            seg        <= blanked ? SEG_BLANK : shadow[idx];
            blank      <= blanked;
            frame_done <= boundary;

            if (load) begin
                pend_buf <= data;
            end
            // A load landing on the boundary bypasses the pending stage entirely.
            if (boundary) begin
                shadow  <= load ? data : pend_buf;
                pending <= 1'b0;
            end else if (load) begin
                pending <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_seg_scan_mux.sv
// Randomised bench for seg_scan_mux: two instances (SCAN_DIV 4 and 1) share
// one stimulus stream and are compared against a slot-arithmetic model.
module tb_seg_scan_mux;

    logic        clk = 1'b0;
    logic        rstn;
    logic [31:0] data;
    logic        load;
    logic        lz_blank;

    logic [2:0]  an_a, an_b;
    logic [3:0]  seg_a, seg_b;
    logic        blank_a, blank_b, pend_a, pend_b, fd_a, fd_b;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    seg_scan_mux #(.DIGITS(8), .SCAN_DIV(4)) u_dut_a (
        .clk(clk), .rstn(rstn), .data(data), .load(load), .lz_blank(lz_blank),
        .an(an_a), .seg(seg_a), .blank(blank_a), .pending(pend_a), .frame_done(fd_a)
    );

    seg_scan_mux #(.DIGITS(8), .SCAN_DIV(1)) u_dut_b (
        .clk(clk), .rstn(rstn), .data(data), .load(load), .lz_blank(lz_blank),
        .an(an_b), .seg(seg_b), .blank(blank_b), .pending(pend_b), .frame_done(fd_b)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s observed=%0h expected=%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Model: after n active edges the scan sits at slot n/div; a frame is 8*div edges.
    int          n       [2];
    logic [31:0] m_show  [2];
    logic [31:0] m_next  [2];
    logic        m_pend  [2];
    logic [2:0]  e_an    [2];
    logic [3:0]  e_seg   [2];
    logic        e_blank [2];
    logic        e_fd    [2];
    logic        armed = 1'b0;

    function automatic int div_of(input int i);
        return (i == 0) ? 4 : 1;
    endfunction

    always @(posedge clk) begin
        int dv, pos;
        logic [31:0] upper;
        logic lead, bnd;
        for (int i = 0; i < 2; i++) begin
            dv = div_of(i);
            if (!rstn) begin
                n[i] = 0; m_show[i] = '0; m_next[i] = '0; m_pend[i] = 1'b0;
                e_an[i] = '0; e_seg[i] = '0; e_blank[i] = 1'b1; e_fd[i] = 1'b0;
            end else begin
                pos   = (n[i] / dv) % 8;
                upper = m_show[i] >> (4 * pos);
                lead  = lz_blank && (pos != 0) && (upper == 32'h0);
                e_an[i]    = pos[2:0];
                e_seg[i]   = lead ? 4'h0 : upper[3:0];
                e_blank[i] = lead;
                bnd        = (n[i] % (8 * dv)) == (8 * dv - 1);
                e_fd[i]    = bnd;
                if (load) begin
                    m_next[i] = data;
                    m_pend[i] = 1'b1;
                end
                if (bnd) begin
                    m_show[i] = m_next[i];
                    m_pend[i] = 1'b0;
                end
                n[i]++;
            end
        end
        armed = 1'b1;
    end

    always @(negedge clk) begin
        if (armed) begin
            chk("an_div4",      32'(an_a),    32'(e_an[0]));
            chk("seg_div4",     32'(seg_a),   32'(e_seg[0]));
            chk("blank_div4",   32'(blank_a), 32'(e_blank[0]));
            chk("pending_div4", 32'(pend_a),  32'(m_pend[0]));
            chk("frame_div4",   32'(fd_a),    32'(e_fd[0]));
            chk("an_div1",      32'(an_b),    32'(e_an[1]));
            chk("seg_div1",     32'(seg_b),   32'(e_seg[1]));
            chk("blank_div1",   32'(blank_b), 32'(e_blank[1]));
            chk("pending_div1", 32'(pend_b),  32'(m_pend[1]));
            chk("frame_div1",   32'(fd_b),    32'(e_fd[1]));
        end
    end

    task automatic cyc(input int count);
        for (int k = 0; k < count; k++) begin
            @(posedge clk);
            @(negedge clk);
        end
    endtask

    // Position within the SCAN_DIV=4 frame at which the next edge will occur.
    task automatic wait_pos(input int target);
        int k;
        k = 0;
        while (((n[0] % 32) != target) && (k < 100)) begin
            cyc(1);
            k++;
        end
        if (k >= 100) chk("wait_pos_timeout", 32'd1, 32'd0);
    endtask

    task automatic do_load(input logic [31:0] value);
        data = value;
        load = 1'b1;
        cyc(1);
        load = 1'b0;
    endtask

    initial begin
        rstn = 1'b0; load = 1'b0; lz_blank = 1'b0; data = '0;
        cyc(3);
        rstn = 1'b1;
        cyc(70);

        wait_pos(12);
        do_load(32'h1234_ABCD);
        cyc(60);

        wait_pos(2);
        do_load(32'h1111_1111);
        wait_pos(15);
        do_load(32'h2222_2222);
        cyc(50);

        wait_pos(31);
        do_load(32'h0000_00F0);
        cyc(40);

        lz_blank = 1'b1;
        cyc(40);
        do_load(32'h0000_0000);
        cyc(70);

        wait_pos(20);
        do_load(32'hDEAD_BEEF);
        rstn = 1'b0;
        cyc(1);
        rstn = 1'b1;
        cyc(40);

        for (int t = 0; t < 1500; t++) begin
            logic [31:0] v;
            int keep;
            v    = $urandom;
            keep = $urandom_range(0, 8);
            v    = (keep == 8) ? v : (v & ((32'h1 << (4 * keep)) - 32'h1));
            data = v;
            load = ($urandom_range(0, 9) == 0);
            if ($urandom_range(0, 49) == 0) lz_blank = ~lz_blank;
            rstn = ($urandom_range(0, 299) != 0);
            cyc(1);
        end
        load = 1'b0;
        rstn = 1'b1;
        cyc(40);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
